// File: rtl/posted_line_buffer.sv
// posted_line_buffer: L2 line <-> memory beat adapter with a one-line
// posted write buffer and read forwarding from the buffered line.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   l2cache_*       : L2 side; level read/write, one-cycle resp pulse
//   bmem_addr/read/write/wdata/ready : memory request and write beats
//   bmem_raddr/rdata/rvalid          : tagged returning read beats
//   wbuf_valid      : posted buffer still holds undrained data
module posted_line_buffer #(
  parameter int XLEN       = 32,
  parameter int LINE_BITS  = 256,
  parameter int BURST_BITS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       l2cache_addr,
  input  logic                  l2cache_read,
  input  logic                  l2cache_write,
  input  logic [LINE_BITS-1:0]  l2cache_wdata,
  output logic [LINE_BITS-1:0]  l2cache_rdata,
  output logic                  l2cache_resp,
  output logic [XLEN-1:0]       bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BURST_BITS-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [XLEN-1:0]       bmem_raddr,
  input  logic [BURST_BITS-1:0] bmem_rdata,
  input  logic                  bmem_rvalid,
  output logic                  wbuf_valid
);

  localparam int BEATS  = LINE_BITS / BURST_BITS;
  localparam int CW     = $clog2(BEATS);
  localparam int OFFSET = $clog2(LINE_BITS / 8);
  localparam logic [XLEN-1:0] OFF_MASK =
    XLEN'((1 << OFFSET) - 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RESP,
    GAP
  } rq_state_e;

  typedef enum logic {
    WB_EMPTY,
    WB_DRAIN
  } wb_state_e;

  rq_state_e            rq_state_q;
  wb_state_e            wb_state_q;
  logic [XLEN-1:0]      rd_addr_q;
  logic [CW-1:0]        rd_beat_q;
  logic [LINE_BITS-1:0] rdata_q;
  logic                 resp_q;
  logic [XLEN-1:0]      wb_addr_q;
  logic [LINE_BITS-1:0] wb_data_q;
  logic [CW-1:0]        wb_beat_q;
  logic                 wb_valid_q;

  logic [XLEN-1:0] line_addr_d;
  logic            wr_accept_d;
  logic            rd_hit_d;
  logic            beat_ok_d;

  assign line_addr_d = l2cache_addr & ~OFF_MASK;
  assign wr_accept_d = (rq_state_q == IDLE) &&
                       l2cache_write && !wb_valid_q;
  assign rd_hit_d    = wb_valid_q && (line_addr_d == wb_addr_q);
  assign beat_ok_d   = bmem_rvalid && (bmem_raddr == rd_addr_q);

  // Request FSM. Write wins over a simultaneous read; reads that
  // miss the buffered line wait in IDLE until it has drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      rq_state_q <= IDLE;
      rd_addr_q  <= '0;
      rd_beat_q  <= '0;
      rdata_q    <= '0;
      resp_q     <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      unique case (rq_state_q)
        IDLE: begin
          if (l2cache_write) begin
            if (!wb_valid_q) begin
              rq_state_q <= RESP;
              resp_q     <= 1'b1;
            end
          end else if (l2cache_read) begin
            if (rd_hit_d) begin
              rdata_q    <= wb_data_q;
              rq_state_q <= RESP;
              resp_q     <= 1'b1;
            end else if (!wb_valid_q) begin
              rd_addr_q  <= line_addr_d;
              rd_beat_q  <= '0;
              rq_state_q <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (bmem_ready) rq_state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (beat_ok_d) begin
            rdata_q[rd_beat_q*BURST_BITS +: BURST_BITS]
              <= bmem_rdata;
            rd_beat_q <= rd_beat_q + CW'(1);
            if (rd_beat_q == LAST) begin
              rq_state_q <= RESP;
              resp_q     <= 1'b1;
            end
          end
        end
        RESP:    rq_state_q <= GAP;
        GAP:     rq_state_q <= IDLE;
        default: rq_state_q <= IDLE;
      endcase
    end
  end

  // Drain FSM. Starts driving beats the cycle right after capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_state_q <= WB_EMPTY;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_beat_q  <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      unique case (wb_state_q)
        WB_EMPTY: begin
          if (wr_accept_d) begin
            wb_addr_q  <= line_addr_d;
            wb_data_q  <= l2cache_wdata;
            wb_beat_q  <= '0;
            wb_valid_q <= 1'b1;
            wb_state_q <= WB_DRAIN;
          end
        end
        WB_DRAIN: begin
          if (bmem_ready) begin
            wb_beat_q <= wb_beat_q + CW'(1);
            if (wb_beat_q == LAST) begin
              wb_valid_q <= 1'b0;
              wb_state_q <= WB_EMPTY;
            end
          end
        end
        default: wb_state_q <= WB_EMPTY;
      endcase
    end
  end

  // Memory port: drain and read request are mutually exclusive
  // by construction, so a simple priority mux is sufficient.
  always_comb begin
    bmem_addr  = '0;
    bmem_wdata = '0;
    bmem_write = (wb_state_q == WB_DRAIN);
    bmem_read  = (rq_state_q == RD_REQ);
    if (bmem_write) begin
      bmem_addr  = wb_addr_q;
      bmem_wdata = wb_data_q[wb_beat_q*BURST_BITS +: BURST_BITS];
    end else if (bmem_read) begin
      bmem_addr = rd_addr_q;
    end
  end

  assign l2cache_rdata = rdata_q;
  assign l2cache_resp  = resp_q;
  assign wbuf_valid    = wb_valid_q;

endmodule
